// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants, types and helpers for the round-robin channel mux
//
// Purpose: widths, port typedefs, output-stage state encoding and the pointer/select helpers
// used by mux_rr_param and rr_arbiter.
// Ports: none (package).
// Configuration: MUX_FORCE_SEL_EN (consumed by mux_rr_param; sel_in_range serves it).
package mux_pkg;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  typedef logic [CH*DW-1:0] in_bus_t;
  typedef logic [SW-1:0]    selectr_t;
  typedef logic [DW-1:0]    dtwidth_t;
  typedef logic [CH-1:0]    ch_vec_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Extra MSB so the compare still works when CH is a power of two.
  function automatic logic sel_in_range(input selectr_t s);
    return ({1'b0, s} < (SW+1)'(CH));
  endfunction

  // Wrap at CH-1 rather than 2^SW-1 so non-power-of-two CH never points at a ghost channel.
  function automatic selectr_t next_ptr(input selectr_t g);
    return (g == selectr_t'(CH - 1)) ? '0 : selectr_t'(g + selectr_t'(1));
  endfunction

endpackage

// File: rtl/mux_rr_param_if.sv
// rtl/mux_rr_param_if.sv - producer/consumer handshake bundle of the round-robin channel mux
//
// Purpose: groups the CH-wide producer side and the single consumer side.
// Signals: in_valid[CH], in_data[CH*DW] (ch i at [i*DW +: DW]), in_ready[CH],
//          out_valid, out_data[DW], out_ch[SW], out_ready.
// Modports: master = environment (producers + sink), slave = the mux.
interface mux_rr_param_if;
  import mux_pkg::*;

  ch_vec_t  in_valid;
  in_bus_t  in_data;
  ch_vec_t  in_ready;
  logic     out_valid;
  dtwidth_t out_data;
  selectr_t out_ch;
  logic     out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/mux_rr_param_rr_arbiter.sv
// rtl/mux_rr_param_rr_arbiter.sv - combinational rotating-priority arbiter (module rr_arbiter)
//
// Purpose: picks the first requesting channel scanning ptr, ptr+1, ..., CH-1, 0, ..., ptr-1.
// Ports: req[CH] in, ptr[SW] in, grant[CH] out (one-hot), grant_idx[SW] out, grant_vld out.
module rr_arbiter
  import mux_pkg::*;
(
  input  ch_vec_t  req,
  input  selectr_t ptr,
  output ch_vec_t  grant,
  output selectr_t grant_idx,
  output logic     grant_vld
);

  logic [SW:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < CH; k++) begin
      // ptr+k modulo CH without a divider: ptr < CH so one subtraction suffices.
      idx = {1'b0, ptr} + (SW+1)'(k);
      if (idx >= (SW+1)'(CH)) begin
        idx = idx - (SW+1)'(CH);
      end
      // The idx < CH guard keeps indices beyond CH out of the grant even if ptr were corrupted.
      if (!grant_vld && (idx < (SW+1)'(CH)) && req[idx[SW-1:0]]) begin
        grant_vld               = 1'b1;
        grant_idx               = idx[SW-1:0];
        grant[idx[SW-1:0]]      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_param.sv
// rtl/mux_rr_param.sv - registered CH-to-1 round-robin channel mux with valid/ready handshake
//
// Purpose: merges CH producer streams into one registered output word tagged with its source.
// Ports: clk, rst_n (async active-low), bus (mux_rr_param_if.slave),
//        force_en/force_sel[SW] only when MUX_FORCE_SEL_EN is defined.
// Configuration: MUX_FORCE_SEL_EN adds a forced-select override that bypasses round-robin.
module mux_rr_param
  import mux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MUX_FORCE_SEL_EN
  input  logic                 force_en,
  input  selectr_t             force_sel,
`endif
  mux_rr_param_if.slave        bus
);

  out_state_e state;
  selectr_t   ptr;
  dtwidth_t   out_data_q;
  selectr_t   out_ch_q;
  logic       out_valid_q;

  ch_vec_t    arb_grant;
  selectr_t   arb_idx;
  logic       arb_vld;

  selectr_t   sel_idx;
  logic       sel_vld;
  logic       force_mode;
  logic       load_en;
  logic       accept;
  ch_vec_t    sel_onehot;

  rr_arbiter u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // Forced selection overrides the arbiter; an invalid or out-of-range channel means no grant.
  always_comb begin
    sel_idx    = arb_idx;
    sel_vld    = arb_vld;
    force_mode = 1'b0;
`ifdef MUX_FORCE_SEL_EN
    if (force_en) begin
      force_mode = 1'b1;
      sel_idx    = force_sel;
      sel_vld    = sel_in_range(force_sel) ? bus.in_valid[force_sel] : 1'b0;
    end
`endif
  end

  // Load when empty, or when full and the sink drains this cycle.
  assign load_en    = (state == ST_EMPTY) || bus.out_ready;
  assign accept     = load_en && sel_vld;
  assign sel_onehot = ch_vec_t'(1) << sel_idx;

  // Depends only on in_valid, ptr, state and out_ready, never on in_ready itself.
  assign bus.in_ready = (rst_n && accept) ? sel_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr         <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state       <= ST_FULL;
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data[sel_idx*DW +: DW];
            out_ch_q    <= sel_idx;
            if (!force_mode) begin
              ptr <= next_ptr(sel_idx);
            end
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            if (accept) begin
              // Drain and reload in the same cycle keeps one word per clock.
              out_data_q <= bus.in_data[sel_idx*DW +: DW];
              out_ch_q   <= sel_idx;
              if (!force_mode) begin
                ptr <= next_ptr(sel_idx);
              end
            end else begin
              // Data and channel hold their last values after draining.
              state       <= ST_EMPTY;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state       <= ST_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_param.sv
// tb/tb_mux_rr_param.sv - directed self-checking bench for mux_rr_param (MUX_FORCE_SEL_EN optional)
module tb_mux_rr_param;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
`ifdef MUX_FORCE_SEL_EN
  logic     force_en;
  selectr_t force_sel;
`endif

  int n_chk = 0;
  int n_err = 0;

  mux_rr_param_if bus ();

  mux_rr_param dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX_FORCE_SEL_EN
    .force_en  (force_en),
    .force_sel (force_sel),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".data"},  32'(bus.out_data),  32'(d));
    chk({tag, ".ch"},    32'(bus.out_ch),    32'(c));
  endtask

  localparam logic [31:0] STD_DATA = {8'h43, 8'h32, 8'h21, 8'h10};

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = STD_DATA;
    bus.out_ready = 1'b1;
`ifdef MUX_FORCE_SEL_EN
    force_en  = 1'b0;
    force_sel = '0;
`endif

    // Reset with every channel requesting.
    tick();
    tick();
    chk("rst.in_ready", 32'(bus.in_ready), 32'h0);
    chk_out("rst", 1'b0, 8'h00, 2'd0);

    // Release: first grant is channel 0, then strict rotation at one word per cycle.
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", 32'(bus.in_ready), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1, 8'h10 + 8'(8'h11 * (i % 4)), 2'(i % 4));
    end

    // Two more words bring 0x21 (ch1) into the register with ptr at 2.
    tick();
    chk_out("pre_bp0", 1'b1, 8'h10, 2'd0);
    tick();
    chk_out("pre_bp1", 1'b1, 8'h21, 2'd1);

    // Backpressure: everything frozen for three cycles.
    bus.out_ready = 1'b0;
    #1;
    chk("bp.in_ready", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("bp%0d", i), 1'b1, 8'h21, 2'd1);
      chk($sformatf("bp%0d.in_ready", i), 32'(bus.in_ready), 32'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel.in_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    chk_out("bp_rel", 1'b1, 8'h32, 2'd2);

    // Single channel: only ch2 valid with 0xA5 (ptr is 3 here, so the scan must wrap).
    bus.in_valid = 4'b0100;
    bus.in_data  = {8'h43, 8'hA5, 8'h21, 8'h10};
    #1;
    chk("single.in_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    chk_out("single", 1'b1, 8'hA5, 2'd2);
    bus.in_valid = 4'b0000;
    #1;
    chk("idle.in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk_out("drain", 1'b0, 8'hA5, 2'd2);

    // Wrap and skip: idle cycles left ptr at 3; ch1 and ch3 valid gives 3,1,3,1.
    bus.in_valid = 4'b1010;
    bus.in_data  = STD_DATA;
    #1;
    chk("wrap.in_ready", 32'(bus.in_ready), 32'b1000);
    tick();
    chk_out("wrap0", 1'b1, 8'h43, 2'd3);
    chk("wrap0.in_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    chk_out("wrap1", 1'b1, 8'h21, 2'd1);
    tick();
    chk_out("wrap2", 1'b1, 8'h43, 2'd3);
    tick();
    chk_out("wrap3", 1'b1, 8'h21, 2'd1);

    // Reset mid-transfer: held word dropped at once, first grant after release is ch0.
    bus.in_valid = 4'b1111;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", 32'(bus.in_ready), 32'h0);
    chk_out("midrst", 1'b0, 8'h00, 2'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrel.in_ready", 32'(bus.in_ready), 32'b0001);

`ifdef MUX_FORCE_SEL_EN
    force_en  = 1'b1;
    force_sel = 2'd1;
    #1;
    chk("force.in_ready", 32'(bus.in_ready), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("force%0d", i), 1'b1, 8'h21, 2'd1);
    end
    // Forced channel not valid: no grant even though others request.
    force_sel    = 2'd2;
    bus.in_valid = 4'b1011;
    #1;
    chk("force_nv.in_ready", 32'(bus.in_ready), 32'h0);
    force_en     = 1'b0;
    bus.in_valid = 4'b1111;
    #1;
    chk("unforce.in_ready", 32'(bus.in_ready), 32'b0001);
`endif
    tick();
    chk_out("post_rst", 1'b1, 8'h10, 2'd0);
    chk("post_rst.in_ready", 32'(bus.in_ready), 32'b0010);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
